// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter and its fill sequencer.
// A block is 8 halfword-aligned 16-bit words; the base is the address above the 4 offset bits.
package mem_arb_pkg;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int MEM_LATENCY       = 4;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_IDX_W        = 3;
  localparam int ADDR_W            = 16;
  localparam int DATA_W            = 16;
  localparam int BASE_W            = ADDR_W - BLOCK_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_e;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [BASE_W-1:0]     base,
                                                  input logic [WORD_IDX_W-1:0] idx);
    return {base, idx, 1'b0};
  endfunction

endpackage

// File: rtl/mem_fill_seq.sv
// Block-fill sequencer: issues one read per cycle for a block and counts returned words.
// Shared by I and D fills; start_i reloads the base and clears both counters.
module mem_fill_seq
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  active_i,
  input  logic [BASE_W-1:0]     base_i,
  input  logic                  data_valid_i,
  output logic                  issue_o,
  output logic [ADDR_W-1:0]     addr_o,
  output logic                  recv_o,
  output logic [WORD_IDX_W-1:0] word_o,
  output logic                  last_o
);

  // ic_q carries one extra bit so "all reads issued" is simply its MSB.
  logic [WORD_IDX_W:0]   ic_q, ic_d;
  logic [WORD_IDX_W-1:0] rc_q, rc_d;
  logic [BASE_W-1:0]     base_q, base_d;

  assign issue_o = active_i && !ic_q[WORD_IDX_W];
  assign addr_o  = word_addr(base_q, ic_q[WORD_IDX_W-1:0]);
  assign recv_o  = active_i && data_valid_i;
  assign word_o  = rc_q;
  assign last_o  = recv_o && (rc_q == WORD_IDX_W'(WORDS_PER_BLOCK - 1));

  always_comb begin
    ic_d   = ic_q;
    rc_d   = rc_q;
    base_d = base_q;
    if (start_i) begin
      ic_d   = '0;
      rc_d   = '0;
      base_d = base_i;
    end else begin
      if (issue_o) ic_d = ic_q + 1'b1;
      // The 3-bit receive counter wraps to 0 on the last word, leaving it ready for the next fill.
      if (recv_o)  rc_d = rc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ic_q   <= '0;
      rc_q   <= '0;
      base_q <= '0;
    end else begin
      ic_q   <= ic_d;
      rc_q   <= rc_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between I-fill, D-fill and D write-through.
// Grant is registered in IDLE; fills take 12 cycles to done, stores 1 cycle; stalls are combinational.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_miss,
  input  logic [ADDR_W-1:0]     icache_miss_addr,
  input  logic                  dcache_miss,
  input  logic [ADDR_W-1:0]     dcache_miss_addr,
  input  logic                  dcache_wr,
  input  logic [ADDR_W-1:0]     dcache_wr_addr,
  input  logic [DATA_W-1:0]     dcache_wr_data,
  input  logic [DATA_W-1:0]     mem_data_out,
  input  logic                  mem_data_valid,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data_in,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  ifill_we,
  output logic                  dfill_we,
  output logic                  ifill_done,
  output logic                  dfill_done,
  output logic                  dwr_done,
  output logic                  if_stall,
  output logic                  mem_stall
);

  arb_state_e state_q, state_d;
  logic       i_wait_q, i_wait_d;

  logic                  fill_start;
  logic                  fill_active;
  logic [BASE_W-1:0]     fill_base;
  logic                  seq_issue;
  logic [ADDR_W-1:0]     seq_addr;
  logic                  seq_recv;
  logic [WORD_IDX_W-1:0] seq_word;
  logic                  seq_last;

  logic unused_offset_bits;
  assign unused_offset_bits = ^{icache_miss_addr[BLOCK_OFFSET_BITS-1:0],
                                dcache_miss_addr[BLOCK_OFFSET_BITS-1:0]};

  assign fill_active = (state_q == I_FILL) || (state_q == D_FILL);

  mem_fill_seq u_fill_seq (
    .clk          (clk),
    .rst          (rst),
    .start_i      (fill_start),
    .active_i     (fill_active),
    .base_i       (fill_base),
    .data_valid_i (mem_data_valid),
    .issue_o      (seq_issue),
    .addr_o       (seq_addr),
    .recv_o       (seq_recv),
    .word_o       (seq_word),
    .last_o       (seq_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      i_wait_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_wait_q <= i_wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_start  = 1'b0;
    fill_base   = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    fill_data   = '0;
    fill_word   = '0;
    ifill_we    = 1'b0;
    dfill_we    = 1'b0;
    ifill_done  = 1'b0;
    dfill_done  = 1'b0;
    dwr_done    = 1'b0;

    case (state_q)
      IDLE: begin
        // A starved I-miss beats any D-side request once it has been passed over.
        if (i_wait_q && icache_miss) state_d = I_FILL;
        else if (dcache_miss)        state_d = D_FILL;
        else if (dcache_wr)          state_d = D_WRITE;
        else if (icache_miss)        state_d = I_FILL;
        fill_start = (state_d == I_FILL) || (state_d == D_FILL);
        fill_base  = (state_d == I_FILL) ? icache_miss_addr[ADDR_W-1:BLOCK_OFFSET_BITS]
                                         : dcache_miss_addr[ADDR_W-1:BLOCK_OFFSET_BITS];
      end
      I_FILL, D_FILL: begin
        mem_enable = seq_issue;
        if (seq_issue) mem_addr = seq_addr;
        if (seq_recv) begin
          fill_data = mem_data_out;
          fill_word = seq_word;
        end
        ifill_we   = seq_recv && (state_q == I_FILL);
        dfill_we   = seq_recv && (state_q == D_FILL);
        ifill_done = seq_last && (state_q == I_FILL);
        dfill_done = seq_last && (state_q == D_FILL);
        if (seq_last) state_d = IDLE;
      end
      D_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = dcache_wr_addr;
        mem_data_in = dcache_wr_data;
        dwr_done    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_wait_d = i_wait_q;
    if ((dfill_done || dwr_done) && icache_miss) i_wait_d = 1'b1;
    if ((state_q == IDLE) && (state_d == I_FILL)) i_wait_d = 1'b0;
  end

  assign if_stall  = icache_miss && !ifill_done;
  assign mem_stall = (dcache_miss && !dfill_done) || (dcache_wr && !dwr_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model and a fill scoreboard.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        icache_miss;
  logic [15:0] icache_miss_addr;
  logic        dcache_miss;
  logic [15:0] dcache_miss_addr;
  logic        dcache_wr;
  logic [15:0] dcache_wr_addr;
  logic [15:0] dcache_wr_data;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        ifill_we, dfill_we;
  logic        ifill_done, dfill_done, dwr_done;
  logic        if_stall, mem_stall;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .fill_data(fill_data), .fill_word(fill_word),
    .ifill_we(ifill_we), .dfill_we(dfill_we),
    .ifill_done(ifill_done), .dfill_done(dfill_done), .dwr_done(dwr_done),
    .if_stall(if_stall), .mem_stall(mem_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory model: reads sampled at an edge appear four cycles later.
  logic        pv_q [4];
  logic [15:0] pa_q [4];
  logic        stray;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= 16'h0;
      end
    end else begin
      pv_q[0] <= mem_enable && !mem_wr;
      pa_q[0] <= mem_addr;
      for (int i = 1; i < 4; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
    end
  end

  assign mem_data_valid = pv_q[3] || stray;
  assign mem_data_out   = pv_q[3] ? memf(pa_q[3]) : 16'hDEAD;

  typedef struct {
    logic        is_i;
    logic [2:0]  idx;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic push_fill(input logic is_i, input logic [15:0] addr);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.is_i = is_i;
      e.idx  = 3'(i);
      e.data = memf({addr[15:4], 3'(i), 1'b0});
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifill_we || dfill_we) begin
      if (sb.size() == 0) begin
        chk("fill_unexpected", {30'b0, ifill_we, dfill_we}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("fill_sel",  {30'b0, ifill_we, dfill_we}, e.is_i ? 32'h2 : 32'h1);
        chk("fill_word", 32'(fill_word), 32'(e.idx));
        chk("fill_data", 32'(fill_data), 32'(e.data));
      end
    end
    if (ifill_done || dfill_done || dwr_done)
      chk("done_onehot", 32'(ifill_done) + 32'(dfill_done) + 32'(dwr_done), 32'h1);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Cycles T+1..T+12 of a fill whose request was seen in IDLE during the current cycle.
  task automatic run_fill(input logic is_i, input logic [15:0] addr);
    for (int k = 1; k <= 12; k++) begin
      next();
      mid();
      chk("fill_mem_en", 32'(mem_enable), (k <= 8) ? 32'h1 : 32'h0);
      if (k <= 8) begin
        chk("fill_mem_wr", 32'(mem_wr), 32'h0);
        chk("fill_mem_addr", 32'(mem_addr), 32'({addr[15:4], 3'(k - 1), 1'b0}));
      end
      chk("fill_we_sel",   32'(is_i ? ifill_we : dfill_we), (k >= 5) ? 32'h1 : 32'h0);
      chk("fill_we_other", 32'(is_i ? dfill_we : ifill_we), 32'h0);
      chk("fill_done",     32'(is_i ? ifill_done : dfill_done), (k == 12) ? 32'h1 : 32'h0);
      chk("fill_dwr_done", 32'(dwr_done), 32'h0);
      if (is_i) chk("fill_if_stall", 32'(if_stall), (k == 12) ? 32'h0 : 32'h1);
    end
  endtask

  initial begin
    rst = 1'b1;
    icache_miss = 0; icache_miss_addr = 0;
    dcache_miss = 0; dcache_miss_addr = 0;
    dcache_wr = 0; dcache_wr_addr = 0; dcache_wr_data = 0;
    stray = 0;
    repeat (3) next();
    rst = 1'b0;
    mid();
    chk("rst_outputs", {mem_enable, mem_wr, ifill_we, dfill_we, ifill_done, dfill_done,
                        dwr_done, if_stall, mem_stall}, 32'h0);
    chk("rst_buses", {mem_addr, mem_data_in}, 32'h0);
    chk("rst_fill_bus", {13'b0, fill_word, fill_data}, 32'h0);

    // I miss alone
    next();
    icache_miss = 1; icache_miss_addr = 16'h1234;
    push_fill(1'b1, 16'h1234);
    mid();
    chk("i_T_stall", 32'(if_stall), 32'h1);
    chk("i_T_men", 32'(mem_enable), 32'h0);
    run_fill(1'b1, 16'h1234);
    next();
    icache_miss = 0;
    mid();
    chk("i_post_men", 32'(mem_enable), 32'h0);
    chk("i_post_stall", 32'(if_stall), 32'h0);

    // I and D miss together: D first, then I by fairness despite a new D miss
    next();
    icache_miss = 1; icache_miss_addr = 16'h0040;
    dcache_miss = 1; dcache_miss_addr = 16'h8000;
    push_fill(1'b0, 16'h8000);
    push_fill(1'b1, 16'h0040);
    mid();
    run_fill(1'b0, 16'h8000);
    chk("id_if_stall_held", 32'(if_stall), 32'h1);
    next();
    dcache_miss_addr = 16'h9000;
    push_fill(1'b0, 16'h9000);
    mid();
    chk("id_T13_men", 32'(mem_enable), 32'h0);
    chk("id_T13_mstall", 32'(mem_stall), 32'h1);
    run_fill(1'b1, 16'h0040);
    next();
    icache_miss = 0;
    mid();
    chk("id_idle_men", 32'(mem_enable), 32'h0);
    run_fill(1'b0, 16'h9000);
    next();
    dcache_miss = 0;
    mid();
    chk("id_end_mstall", 32'(mem_stall), 32'h0);

    // Store alone, with stray valids in D_WRITE and IDLE
    next();
    dcache_wr = 1; dcache_wr_addr = 16'h00A2; dcache_wr_data = 16'hBEEF;
    mid();
    chk("st_T_mstall", 32'(mem_stall), 32'h1);
    chk("st_T_men", 32'(mem_enable), 32'h0);
    next();
    stray = 1;
    mid();
    chk("st_en_wr", {30'b0, mem_enable, mem_wr}, 32'h3);
    chk("st_addr", 32'(mem_addr), 32'h00A2);
    chk("st_data", 32'(mem_data_in), 32'hBEEF);
    chk("st_done", 32'(dwr_done), 32'h1);
    chk("st_mstall", 32'(mem_stall), 32'h0);
    chk("st_no_fill", {30'b0, ifill_we, dfill_we}, 32'h0);
    next();
    dcache_wr = 0;
    mid();
    chk("idle_stray_we", {30'b0, ifill_we, dfill_we}, 32'h0);
    chk("idle_stray_done", 32'(dwr_done), 32'h0);
    chk("idle_men", 32'(mem_enable), 32'h0);
    next();
    stray = 0;

    // Store miss: fill then write
    next();
    dcache_miss = 1; dcache_miss_addr = 16'h0100;
    dcache_wr = 1; dcache_wr_addr = 16'h0100; dcache_wr_data = 16'h1111;
    push_fill(1'b0, 16'h0100);
    mid();
    run_fill(1'b0, 16'h0100);
    chk("sm_T12_mstall", 32'(mem_stall), 32'h1);
    next();
    dcache_miss = 0;
    mid();
    chk("sm_T13_mstall", 32'(mem_stall), 32'h1);
    chk("sm_T13_men", 32'(mem_enable), 32'h0);
    next();
    mid();
    chk("sm_T14_en_wr", {30'b0, mem_enable, mem_wr}, 32'h3);
    chk("sm_T14_addr", 32'(mem_addr), 32'h0100);
    chk("sm_T14_data", 32'(mem_data_in), 32'h1111);
    chk("sm_T14_done", 32'(dwr_done), 32'h1);
    chk("sm_T14_mstall", 32'(mem_stall), 32'h0);
    next();
    dcache_wr = 0;
    mid();
    chk("sm_end_men", 32'(mem_enable), 32'h0);

    // Reset in the middle of an I fill
    next();
    icache_miss = 1; icache_miss_addr = 16'h2000;
    push_fill(1'b1, 16'h2000);
    mid();
    for (int k = 1; k <= 5; k++) begin
      next();
      mid();
    end
    next();
    rst = 1;
    mid();
    next();
    rst = 0;
    icache_miss = 0;
    sb.delete();
    mid();
    chk("rs_T7_men", 32'(mem_enable), 32'h0);
    chk("rs_T7_fill", {29'b0, ifill_we, ifill_done, dfill_we}, 32'h0);
    next();
    icache_miss = 1;
    push_fill(1'b1, 16'h2000);
    mid();
    chk("rs_T8_fill", {30'b0, ifill_we, ifill_done}, 32'h0);
    chk("rs_T8_stall", 32'(if_stall), 32'h1);
    run_fill(1'b1, 16'h2000);
    next();
    icache_miss = 0;
    mid();
    chk("rs_end_men", 32'(mem_enable), 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported, pipelined main memory between the I-cache and D-cache miss handlers and the D-cache write-through path. Sequences 8-word block fills and single-word stores, streams returned words into the requesting cache, and raises the fetch/memory-stage stalls that the pipeline ORs with the hazard-unit stall. Sits between the two cache controllers and the 4-cycle-latency memory model.

## Interface
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; the block is 16 bytes.
- MEM_LATENCY, 4, cycles from an issued read to its `mem_data_valid`.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- icache_miss  in  1  level; held until `ifill_done`.
- icache_miss_addr  in  16  byte address of the missing fetch.
- dcache_miss  in  1  level; held until `dfill_done`.
- dcache_miss_addr  in  16  byte address of the missing load or store.
- dcache_wr  in  1  write-through store request; held until `dwr_done`.
- dcache_wr_addr  in  16  store byte address.
- dcache_wr_data  in  16  store data.
- mem_data_out  in  16  read data from memory.
- mem_data_valid  in  1  `mem_data_out` is valid.
- mem_enable  out  1  memory access this cycle.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  access address.
- mem_data_in  out  16  write data.
- fill_data  out  16  returned word, shared by both caches.
- fill_word  out  3  word index within the block.
- ifill_we, dfill_we  out  1  write `fill_data` into the I-cache or D-cache.
- ifill_done, dfill_done, dwr_done  out  1  one-cycle completion pulses.
- if_stall, mem_stall  out  1  pipeline stalls.

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE. The grant is chosen in IDLE and is registered; the new state takes effect next cycle.
- Priority in IDLE: `dcache_miss` > `dcache_wr` > `icache_miss`.
  - Fairness override: if `i_wait` is set and `icache_miss` is high, I_FILL wins.
  - `i_wait` is set when a D-side transaction completes while `icache_miss` is high. It is cleared on an I_FILL grant.
- FILL (I_FILL or D_FILL):
  - Block base = miss_addr[15:4], latched at grant.
  - Issue counter `ic` runs 0..7, one read per cycle: `mem_enable`=1, `mem_wr`=0, `mem_addr`={base, ic, 1'b0}.
  - After 8 issues, `mem_enable`=0.
  - Receive counter `rc` increments on each `mem_data_valid`. The same cycle drives `fill_word`=rc, `fill_data`=`mem_data_out`, and the selected `*fill_we`=1.
  - On `rc`==7 with valid: pulse `*fill_done` in that cycle, then go to IDLE.
  - The fill always runs to completion, even if the miss drops.
- D_WRITE: one cycle with `mem_enable`=1, `mem_wr`=1, `mem_addr`=`dcache_wr_addr`, `mem_data_in`=`dcache_wr_data`. Pulse `dwr_done`, then go to IDLE.
- Store that misses (`dcache_miss` and `dcache_wr` both high): D_FILL first, then D_WRITE.
- `mem_data_valid` outside FILL is ignored. `rc` never exceeds 7.
- Stalls:
  - `if_stall` = `icache_miss` & ~`ifill_done`.
  - `mem_stall` = (`dcache_miss` & ~`dfill_done`) | (`dcache_wr` & ~`dwr_done`).

## Timing
- Reset values:
  - State IDLE; `ic`, `rc`, `i_wait` = 0.
  - All outputs 0: memory outputs, fill outputs, every done pulse, and both stalls.
  - Stalls, being combinational, follow the miss inputs after reset.
- Fill latency:
  - Miss seen in IDLE at cycle T; reads issue at T+1..T+8.
  - Valids arrive at T+5..T+12; done pulses at T+12.
  - Back in IDLE at T+13. The earliest next grant is evaluated at T+13 and takes effect at T+14.
- Store latency: request seen at T; write at T+1 with `dwr_done` at T+1; IDLE at T+2.
- Reset mid-operation: returns to IDLE next edge and no done pulse follows. The memory shares `rst`, so its in-flight reads are discarded too.
- Done pulses are exactly one cycle and never coincide with each other.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum;
  - `WORDS_PER_BLOCK`, `MEM_LATENCY`, `BLOCK_OFFSET_BITS` (= 4);
  - the word-index width (= 3).
- One natural sub-module, `mem_fill_seq`, holds the `ic`/`rc` counters, address generation and last-word detect. It is instantiated once and reused for both fill types.
- Arbitration, `i_wait` and stall logic live in the top level.

## Test plan
- I miss alone, addr 0x1234:
  - reads 0x1230, 0x1232, …, 0x123E at T+1..T+8;
  - `ifill_we` with `fill_word` 0..7 at T+5..T+12;
  - `ifill_done` at T+12; `if_stall` high T..T+11, low at T+12.
- I and D miss same cycle (I 0x0040, D 0x8000):
  - D_FILL first, `dfill_done` at T+12; `i_wait` set.
  - I_FILL is granted at T+13 even if a new `dcache_miss` is raised then.
- Store alone, 0x00A2/0xBEEF: single `mem_wr` cycle at T+1 with addr 0x00A2, data 0xBEEF, `dwr_done` at T+1; no fill strobes.
- Store miss 0x0100/0x1111:
  - D_FILL of 0x0100..0x010E with `dfill_done` at T+12;
  - D_WRITE of 0x0100 at T+14; `mem_stall` high until T+14.
- `rst` at T+6 of an I fill: IDLE at T+7; no `ifill_we`/`ifill_done` at T+7..T+12; a new miss at T+8 restarts from word 0.
- Stray `mem_data_valid` in IDLE and D_WRITE: no `*fill_we` and no counter change.
